// File: rtl/reg_wb_ctrl_pkg.sv
// rtl/reg_wb_ctrl_pkg.sv - shared widths, FSM encoding and writeback entry type
package reg_wb_ctrl_pkg;

  localparam int WB_DW    = 8;
  localparam int WB_AW    = 2;
  localparam int WB_NREG  = 1 << WB_AW;
  localparam int WB_DEPTH = 4;

  typedef enum logic [0:0] {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  typedef struct packed {
    logic [WB_AW-1:0] n;
    logic [WB_DW-1:0] d;
  } wb_entry_t;

endpackage

// File: rtl/reg_wb_ctrl_if.sv
// rtl/reg_wb_ctrl_if.sv - ALU and memory-load result handshakes into the writeback controller
interface reg_wb_ctrl_if import reg_wb_ctrl_pkg::*; #(
  parameter int DW = WB_DW,
  parameter int AW = WB_AW
);

  logic          a_valid;
  logic          a_ready;
  logic [AW-1:0] a_n;
  logic [DW-1:0] a_d;
  logic          m_valid;
  logic          m_ready;
  logic [AW-1:0] m_n;
  logic [DW-1:0] m_d;

  modport master (
    output a_valid, a_n, a_d, m_valid, m_n, m_d,
    input  a_ready, m_ready
  );

  modport slave (
    input  a_valid, a_n, a_d, m_valid, m_n, m_d,
    output a_ready, m_ready
  );

endinterface

// File: rtl/reg_wb_ctrl_wb_fifo.sv
// rtl/reg_wb_ctrl_wb_fifo.sv - in-order writeback FIFO exposing every slot for hazard tracking
module wb_fifo import reg_wb_ctrl_pkg::*; #(
  parameter int  DEPTH   = WB_DEPTH,
  parameter type entry_t = wb_entry_t
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  entry_t           push_data_i,
  input  logic             pop_i,
  output logic             full_o,
  output logic             empty_o,
  output entry_t           head_o,
  output entry_t           ent_o [DEPTH],
  output logic [DEPTH-1:0] ent_valid_o
);

  localparam int PW = $clog2(DEPTH);

  entry_t        mem_q [DEPTH];
  logic [PW-1:0] wr_q;
  logic [PW-1:0] rd_q;
  logic [PW:0]   cnt_q;
  logic          do_push;
  logic          do_pop;

  assign full_o  = (cnt_q == (PW+1)'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign head_o  = mem_q[rd_q];
  assign ent_o   = mem_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + PW'(1);
      if (do_pop)  rd_q <= rd_q + PW'(1);
      cnt_q <= cnt_q + (PW+1)'(do_push) - (PW+1)'(do_pop);
    end
  end

  // Payload needs no reset: a slot is only observed while ent_valid_o marks it live.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= push_data_i;
  end

  always_comb begin
    ent_valid_o = '0;
    for (int i = 0; i < DEPTH; i++) begin
      ent_valid_o[i] = ({1'b0, PW'(i) - rd_q} < cnt_q);
    end
  end

endmodule

// File: rtl/reg_wb_ctrl.sv
// rtl/reg_wb_ctrl.sv - register file writeback controller: init sweep, producer arbitration,
// in-order issue and pending-write mask
module reg_wb_ctrl import reg_wb_ctrl_pkg::*; #(
  parameter int DW    = WB_DW,
  parameter int AW    = WB_AW,
  parameter int DEPTH = WB_DEPTH
) (
  input  logic                clk,
  input  logic                rst_n,
  reg_wb_ctrl_if.slave        wb,
  input  logic                hold_i,
  output logic [AW-1:0]       nd_o,
  output logic [DW-1:0]       di_o,
  output logic                reg_we_o,
  output logic [(1<<AW)-1:0]  pend_o,
  output logic                init_done_o
);

  typedef struct packed {
    logic [AW-1:0] n;
    logic [DW-1:0] d;
  } entry_t;

  state_t           state_q, state_d;
  logic [AW-1:0]    cnt_q, cnt_d;
  logic             reg_we_q, reg_we_d;
  logic [AW-1:0]    nd_q, nd_d;
  logic [DW-1:0]    di_q, di_d;
  logic             run, a_ready, m_ready;
  logic             full, empty, push, pop;
  entry_t           push_ent, head;
  entry_t           ent [DEPTH];
  logic [DEPTH-1:0] ent_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_INIT;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (state_q == ST_INIT) begin
      cnt_d = cnt_q + AW'(1);
      if (&cnt_q) state_d = ST_RUN;
    end
  end

  always_comb begin
    run     = (state_q == ST_RUN);
    a_ready = run && !full;
    m_ready = run && !full && !wb.a_valid;
  end

  assign wb.a_ready  = a_ready;
  assign wb.m_ready  = m_ready;
  assign init_done_o = run;

  // ALU has fixed priority; m_ready already excludes a cycle where A is offering.
  assign push = (wb.a_valid && a_ready) || (wb.m_valid && m_ready);
  assign pop  = run && !empty && !hold_i;

  always_comb begin
    push_ent.n = wb.a_valid ? wb.a_n : wb.m_n;
    push_ent.d = wb.a_valid ? wb.a_d : wb.m_d;
  end

  wb_fifo #(
    .DEPTH   (DEPTH),
    .entry_t (entry_t)
  ) u_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .push_i      (push),
    .push_data_i (push_ent),
    .pop_i       (pop),
    .full_o      (full),
    .empty_o     (empty),
    .head_o      (head),
    .ent_o       (ent),
    .ent_valid_o (ent_valid)
  );

  always_comb begin
    reg_we_d = 1'b0;
    nd_d     = nd_q;
    di_d     = di_q;
    if (!run) begin
      reg_we_d = 1'b1;
      nd_d     = cnt_q;
      di_d     = '0;
    end else if (pop) begin
      reg_we_d = 1'b1;
      nd_d     = head.n;
      di_d     = head.d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      reg_we_q <= 1'b0;
      nd_q     <= '0;
      di_q     <= '0;
    end else begin
      reg_we_q <= reg_we_d;
      nd_q     <= nd_d;
      di_q     <= di_d;
    end
  end

  assign reg_we_o = reg_we_q;
  assign nd_o     = nd_q;
  assign di_o     = di_q;

  // A register stays pending until its last queued write has been presented on the port.
  always_comb begin
    pend_o = '0;
    for (int j = 0; j < DEPTH; j++) begin
      if (ent_valid[j]) pend_o[ent[j].n] = 1'b1;
    end
    if (reg_we_q) pend_o[nd_q] = 1'b1;
  end

endmodule

// File: tb/tb_reg_wb_ctrl.sv
// tb/tb_reg_wb_ctrl.sv - directed scoreboard bench for reg_wb_ctrl
module tb_reg_wb_ctrl;
  import reg_wb_ctrl_pkg::*;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic                hold = 1'b0;
  logic [WB_AW-1:0]    nd;
  logic [WB_DW-1:0]    di;
  logic                reg_we;
  logic [WB_NREG-1:0]  pend;
  logic                init_done;

  int n_cmp = 0;
  int n_err = 0;

  wb_entry_t          sb[$];
  wb_entry_t          mon_ent;
  logic [WB_NREG-1:0] mon_pend;

  reg_wb_ctrl_if ifc ();

  reg_wb_ctrl dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .wb          (ifc),
    .hold_i      (hold),
    .nd_o        (nd),
    .di_o        (di),
    .reg_we_o    (reg_we),
    .pend_o      (pend),
    .init_done_o (init_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_init();
    wb_entry_t e;
    for (int i = 0; i < WB_NREG; i++) begin
      e.n = WB_AW'(i);
      e.d = '0;
      sb.push_back(e);
    end
  endtask

  task automatic push_a(input logic [WB_AW-1:0] n, input logic [WB_DW-1:0] d);
    wb_entry_t e;
    ifc.a_valid = 1'b1;
    ifc.a_n     = n;
    ifc.a_d     = d;
    #1;
    chk("a_ready_on_push", ifc.a_ready, 1);
    tick();
    ifc.a_valid = 1'b0;
    e.n = n;
    e.d = d;
    sb.push_back(e);
  endtask

  // Every presented write must match the scoreboard head; PEND must equal the
  // union of destinations still owed to the register file.
  always @(negedge clk) begin
    if (rst_n) begin
      if (init_done) begin
        mon_pend = '0;
        foreach (sb[k]) mon_pend[sb[k].n] = 1'b1;
        chk("pend_vs_model", pend, mon_pend);
      end
      if (reg_we) begin
        if (sb.size() == 0) begin
          chk("unexpected_write", {nd, di}, 0);
        end else begin
          mon_ent = sb.pop_front();
          chk("wr_nd", nd, mon_ent.n);
          chk("wr_di", di, mon_ent.d);
        end
      end
    end
  end

  initial begin
    wb_entry_t e;
    ifc.a_valid = 1'b0;
    ifc.a_n     = '0;
    ifc.a_d     = '0;
    ifc.m_valid = 1'b0;
    ifc.m_n     = '0;
    ifc.m_d     = '0;

    #1;
    chk("rst_reg_we", reg_we, 0);
    chk("rst_nd", nd, 0);
    chk("rst_di", di, 0);
    chk("rst_pend", pend, 0);
    chk("rst_init_done", init_done, 0);
    chk("rst_a_ready", ifc.a_ready, 0);
    chk("rst_m_ready", ifc.m_ready, 0);
    expect_init();
    #1 rst_n = 1'b1;

    for (int i = 0; i < WB_NREG; i++) begin
      tick();
      chk("init_we", reg_we, 1);
      chk("init_nd", nd, i);
      chk("init_di", di, 0);
      chk("init_pend", pend, 1 << i);
      chk("init_done", init_done, (i == WB_NREG-1));
      chk("init_a_ready", ifc.a_ready, (i == WB_NREG-1));
      chk("init_m_ready", ifc.m_ready, (i == WB_NREG-1));
    end
    tick();
    chk("idle_we", reg_we, 0);

    push_a(2'd1, 8'h55);
    chk("alu_k_we", reg_we, 0);
    chk("alu_k_pend", pend, 4'b0010);
    tick();
    chk("alu_k1_we", reg_we, 1);
    chk("alu_k1_nd", nd, 1);
    chk("alu_k1_di", di, 8'h55);
    tick();
    chk("alu_k2_we", reg_we, 0);
    chk("alu_k2_pend", pend, 0);

    ifc.m_valid = 1'b1;
    ifc.m_n     = 2'd3;
    ifc.m_d     = 8'h3C;
    ifc.a_valid = 1'b1;
    ifc.a_n     = 2'd0;
    ifc.a_d     = 8'hAA;
    #1;
    chk("arb_a_ready", ifc.a_ready, 1);
    chk("arb_m_ready", ifc.m_ready, 0);
    tick();
    ifc.a_valid = 1'b0;
    e.n = 2'd0; e.d = 8'hAA; sb.push_back(e);
    #1;
    chk("arb_m_ready_after", ifc.m_ready, 1);
    tick();
    ifc.m_valid = 1'b0;
    e.n = 2'd3; e.d = 8'h3C; sb.push_back(e);
    chk("arb_out0_nd", nd, 0);
    chk("arb_out0_di", di, 8'hAA);
    tick();
    chk("arb_out1_nd", nd, 3);
    chk("arb_out1_di", di, 8'h3C);
    tick();
    chk("arb_idle_we", reg_we, 0);

    hold = 1'b1;
    for (int i = 0; i < 4; i++) push_a(WB_AW'(i), 8'h10 + 8'(i));
    ifc.a_valid = 1'b1;
    ifc.a_n     = 2'd0;
    ifc.a_d     = 8'h14;
    #1;
    chk("full_a_ready", ifc.a_ready, 0);
    chk("full_m_ready", ifc.m_ready, 0);
    chk("full_pend", pend, 4'b1111);
    tick();
    chk("hold_we", reg_we, 0);
    chk("hold_a_ready", ifc.a_ready, 0);
    hold = 1'b0;
    tick();
    chk("unhold_we", reg_we, 1);
    chk("unhold_nd", nd, 0);
    chk("unhold_di", di, 8'h10);
    chk("unhold_a_ready", ifc.a_ready, 1);
    tick();
    ifc.a_valid = 1'b0;
    e.n = 2'd0; e.d = 8'h14; sb.push_back(e);
    for (int i = 0; i < 20 && sb.size() > 0; i++) tick();
    tick();
    chk("hold_drained", sb.size(), 0);
    chk("hold_idle_we", reg_we, 0);

    push_a(2'd2, 8'h11);
    push_a(2'd2, 8'h22);
    chk("same_first_di", di, 8'h11);
    chk("same_first_pend2", pend[2], 1);
    tick();
    chk("same_second_di", di, 8'h22);
    chk("same_second_pend2", pend[2], 1);
    tick();
    chk("same_done_pend", pend, 0);

    hold = 1'b1;
    push_a(2'd1, 8'h61);
    push_a(2'd2, 8'h62);
    push_a(2'd3, 8'h63);
    hold = 1'b0;
    tick();
    chk("pre_rst_we", reg_we, 1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_we", reg_we, 0);
    chk("mid_rst_nd", nd, 0);
    chk("mid_rst_di", di, 0);
    chk("mid_rst_pend", pend, 0);
    chk("mid_rst_init_done", init_done, 0);
    sb.delete();
    expect_init();
    tick();
    chk("rst_held_we", reg_we, 0);
    rst_n = 1'b1;
    for (int i = 0; i < WB_NREG; i++) begin
      tick();
      chk("reinit_nd", nd, i);
      chk("reinit_di", di, 0);
    end
    for (int i = 0; i < 6; i++) tick();
    chk("reinit_no_stale", reg_we, 0);
    chk("final_drained", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
